clk_div_monitor: RTL
====================

# clk_div_monitor

Checks the divided clock produced by the clock divider stage, sampled in the reference clock domain. On request it measures one full period and the high time of the divided clock in reference-clock cycles. It compares both against the programmed divide ratio and reports the result with a one-cycle done pulse. It is the self-check and bring-up stage directly downstream of the divider.

## Interface
- `RATIO_WD`, 4: width of the divide-ratio field; matches the divider.
- `SYNC_STAGES`, 2: synchronizer depth on `I_div_clk`; minimum 2.
- `CNT_WD`, `RATIO_WD+2`: width of the internal measurement counter.
- `TO_CYC`, `2**(RATIO_WD+1)`: cycles without a qualifying edge before timeout.
- `I_ref_clk`  in  1  reference clock; the only clock.
- `I_rst`  in  1  reset, asynchronous, active-high.
- `I_start`  in  1  measurement request; sampled only in IDLE.
- `I_div_clk`  in  1  divided clock under test, treated as asynchronous data.
- `I_exp_ratio`  in  RATIO_WD  expected divide ratio; captured when `I_start` is accepted.
- `O_busy`  out  1  high in ARM, MEAS_HIGH and MEAS_LOW.
- `O_done`  out  1  one-cycle pulse when the result registers update.
- `O_period`  out  RATIO_WD+1  measured period in cycles; 0 on timeout.
- `O_high`  out  RATIO_WD+1  measured high time in cycles; 0 on timeout.
- `O_match`  out  1  `O_period` equals the captured ratio.
- `O_duty_ok`  out  1  `O_high` equals the captured ratio >> 1.
- `O_timeout`  out  1  last measurement timed out.

## Operation
- `I_div_clk` passes through `SYNC_STAGES` flops to give `s`. A further flop gives `s_d`.
  - `rise = s & !s_d`.
  - `fall = !s & s_d`.
  - The sync pipeline runs continuously, including in IDLE.
- FSM states: IDLE, ARM, MEAS_HIGH, MEAS_LOW.
  - IDLE: when `I_start` is high, capture `I_exp_ratio`, clear the timer, and go to ARM.
  - ARM: on `rise`, set `cnt <= 1`, clear the timer, and go to MEAS_HIGH. If `I_div_clk` is already high at start, wait for the next genuine rise.
  - MEAS_HIGH: `cnt++` every cycle. On `fall`, latch `high_q <= cnt` (value before increment) and go to MEAS_LOW.
  - MEAS_LOW: `cnt++` every cycle. On `rise`, finish:
    - `O_period <= cnt`, `O_high <= high_q`.
    - `O_match <= (cnt == exp)`.
    - `O_duty_ok <= (high_q == exp>>1)`.
    - `O_timeout <= 0`, `O_done <= 1`.
    - Go to IDLE.
- Timer:
  - Counts every cycle in ARM, MEAS_HIGH and MEAS_LOW; resets on each accepted edge.
  - On reaching `TO_CYC`, finish with `O_timeout=1` and `O_period=O_high=O_match=O_duty_ok=0`, then go to IDLE.
  - Timeout takes priority over an edge arriving in the same cycle.
- `cnt` saturates at `2**CNT_WD-1`. It is truncated to RATIO_WD+1 bits on output; with default parameters the timeout always fires first.
- `I_start` while busy is ignored. `I_start` in the cycle `O_done` is high is accepted, because the FSM is already in IDLE.
- A constant `I_div_clk` (divider bypassed or disabled) gives a timeout, not a hang.

## Timing
- Reset: state IDLE; `O_busy`, `O_done`, `O_period`, `O_high`, `O_match`, `O_duty_ok`, `O_timeout` all 0; sync flops 0.
- All outputs are registered.
- `O_done` rises exactly one cycle after the closing `rise` or timeout condition is seen.
- Edge detection lags `I_div_clk` by `SYNC_STAGES+1` cycles. The lag is equal for both edges, so measured values are unaffected.
- Worst-case latency from start to done is under 3 × period + `SYNC_STAGES` + 2 cycles. Timeout latency is `TO_CYC` + 1 cycles after the last edge.
- Results hold until the next `O_done`.
- `O_busy` goes low in the same cycle `O_done` goes high.
- Asserting reset mid-measurement aborts immediately. No `O_done` is produced.

## Structure
- Shared package `clk_div_pkg`:
  - state encoding (IDLE/ARM/MEAS_HIGH/MEAS_LOW);
  - the default `TO_CYC` derivation from `RATIO_WD`;
  - the expected-high-time rule (ratio >> 1), also used by the divider bench.
- One sub-module, `bit_sync`: N-flop synchronizer with parameter `STAGES`, asynchronous active-high reset to 0.

## Test plan
- Ratio 4 clock (2 high / 2 low), exp 4, start → done with period 4, high 2, match 1, duty_ok 1, timeout 0.
- Ratio 5 clock (2 high / 3 low), exp 5 → period 5, high 2, match 1, duty_ok 1.
- `I_div_clk` held at 0, exp 4, `RATIO_WD`=4 → `O_timeout`=1 exactly 33 cycles after start accepted (32-cycle timeout + 1); period 0, high 0, match 0.
- Ratio 6 clock (3/3), exp 4 → period 6, high 3, match 0, duty_ok 0.
- Clock 4 high / 2 low, exp 6 → period 6, high 4, match 1, duty_ok 0.
- Reset asserted in MEAS_HIGH → all outputs 0 and no done pulse. Start pulsed while busy → ignored, one done only. Start in the done cycle → a second measurement begins.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Definitions shared by the clock-divider monitor and the
//               divider bench: monitor state encoding, the default timeout
//               derivation and the expected-high-time rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    // Monitor FSM encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARM       = 2'd1;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd2;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd3;

    // Default timeout: twice the largest ratio the field can express, so a
    // healthy divided clock always produces an edge well before it expires.
    function automatic int to_cyc_default(input int ratio_wd);
        return 1 << (ratio_wd + 1);
    endfunction

    // A divider with ratio R holds its output high for floor(R/2) cycles.
    function automatic int exp_high_time(input int ratio);
        return ratio >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_monitor_bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : N-flop single-bit synchronizer, asynchronous active-high
//               reset to 0.
// Ports       : clk - destination clock
//               rst - asynchronous active-high reset
//               d   - asynchronous input bit
//               q   - synchronized output bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module      : clk_div_monitor
// Description : Measures one full period and the high time of the divided
//               clock in reference-clock cycles and compares both against the
//               programmed divide ratio. Reports with a one-cycle done pulse.
// Ports       : I_ref_clk   - reference clock (only clock)
//               I_rst       - asynchronous active-high reset
//               I_start     - measurement request, sampled in IDLE
//               I_div_clk   - divided clock under test (asynchronous data)
//               I_exp_ratio - expected divide ratio, captured on start
//               O_busy      - measurement in progress
//               O_done      - one-cycle result-update pulse
//               O_period    - measured period (0 on timeout)
//               O_high      - measured high time (0 on timeout)
//               O_match     - period equals expected ratio
//               O_duty_ok   - high time equals expected ratio >> 1
//               O_timeout   - last measurement timed out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WD      = RATIO_WD + 2,
    parameter int TO_CYC      = to_cyc_default(RATIO_WD)
) (
    input  logic                I_ref_clk,
    input  logic                I_rst,
    input  logic                I_start,
    input  logic                I_div_clk,
    input  logic [RATIO_WD-1:0] I_exp_ratio,
    output logic                O_busy,
    output logic                O_done,
    output logic [RATIO_WD:0]   O_period,
    output logic [RATIO_WD:0]   O_high,
    output logic                O_match,
    output logic                O_duty_ok,
    output logic                O_timeout
);

    localparam int                TMR_WD    = $clog2(TO_CYC + 1);
    localparam logic [TMR_WD-1:0] TMR_LIMIT = TMR_WD'(TO_CYC);
    localparam logic [CNT_WD-1:0] CNT_MAX   = '1;

    logic                s;
    logic                s_d;
    logic                rise;
    logic                fall;
    state_t              state;
    logic [RATIO_WD-1:0] exp_q;
    logic [RATIO_WD-1:0] exp_half;
    logic [CNT_WD-1:0]   cnt;
    logic [CNT_WD-1:0]   cnt_inc;
    logic [CNT_WD-1:0]   high_q;
    logic [TMR_WD-1:0]   timer;
    logic                timed_out;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (I_ref_clk),
        .rst (I_rst),
        .d   (I_div_clk),
        .q   (s)
    );

    // Extra flop for edge detection; both edges see the same lag, so the
    // measured widths are not skewed by the synchronizer.
    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise      = s & ~s_d;
    assign fall      = ~s & s_d;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign exp_half  = RATIO_WD'(exp_high_time(int'(exp_q)));
    // Only meaningful in busy states; IDLE never looks at it.
    assign timed_out = (timer == TMR_LIMIT);

    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            state     <= ST_IDLE;
            exp_q     <= '0;
            cnt       <= '0;
            high_q    <= '0;
            timer     <= '0;
            O_busy    <= 1'b0;
            O_done    <= 1'b0;
            O_period  <= '0;
            O_high    <= '0;
            O_match   <= 1'b0;
            O_duty_ok <= 1'b0;
            O_timeout <= 1'b0;
        end else begin
            O_done <= 1'b0;
            if (state != ST_IDLE && timed_out) begin
                // Timeout wins over any edge seen in the same cycle.
                state     <= ST_IDLE;
                O_busy    <= 1'b0;
                O_done    <= 1'b1;
                O_period  <= '0;
                O_high    <= '0;
                O_match   <= 1'b0;
                O_duty_ok <= 1'b0;
                O_timeout <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (I_start) begin
                            exp_q  <= I_exp_ratio;
                            timer  <= '0;
                            O_busy <= 1'b1;
                            state  <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        // A clock already high at start produces no rise here,
                        // so the measurement starts on the next genuine rise.
                        if (rise) begin
                            cnt   <= CNT_WD'(1);
                            timer <= '0;
                            state <= ST_MEAS_HIGH;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_MEAS_HIGH: begin
                        cnt <= cnt_inc;
                        if (fall) begin
                            high_q <= cnt;
                            timer  <= '0;
                            state  <= ST_MEAS_LOW;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin // ST_MEAS_LOW
                        cnt   <= cnt_inc;
                        timer <= timer + 1'b1;
                        if (rise) begin
                            O_period  <= cnt[RATIO_WD:0];
                            O_high    <= high_q[RATIO_WD:0];
                            O_match   <= (cnt == CNT_WD'(exp_q));
                            O_duty_ok <= (high_q == CNT_WD'(exp_half));
                            O_timeout <= 1'b0;
                            O_done    <= 1'b1;
                            O_busy    <= 1'b0;
                            timer     <= '0;
                            state     <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
